sha256_msg_padder: RTL and testbench

//  Upstream feeder for the SHA256 core. Accepts a raw message as a byte stream and applies FIPS 180-4 padding
//  (0x80, zero fill, 64-bit big-endian bit length). Emits each 512-bit block as one core_soc pulse followed
//  by 16 big-endian words on consecutive cycles. Waits for core_eoc before starting the next block.

---
 rtl/sha256_msg_padder_pkg.sv | 31 +++
 rtl/sha256_msg_padder_if.sv | 29 ++
 rtl/sha256_blk_buf.sv | 30 +++
 rtl/sha256_msg_padder.sv | 187 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_msg_padder_pkg.sv
// Shared constants, state/pending enums and the length-byte helper for the SHA-256 message padder.
package sha256_pkg;

  localparam int SHA_BLK_WORDS = 16;
  localparam int SHA_BLK_BYTES = 64;
  localparam int SHA_LEN_POS   = 56;
  localparam logic [7:0] SHA_PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_PAD      = 3'd2,
    ST_SOC      = 3'd3,
    ST_SEND     = 3'd4,
    ST_WAIT_EOC = 3'd5,
    ST_DONE     = 3'd6
  } padder_state_t;

  // Which generated block (if any) follows the block currently held in the buffer.
  typedef enum logic [1:0] {
    PEND_NONE  = 2'd0,
    PEND_ZERO  = 2'd1,
    PEND_PAD80 = 2'd2
  } pend_t;

  // Big-endian byte of the 64-bit length trailer; idx 0 selects byte 56 (the MSB).
  function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] idx);
    return len[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input, block output and status bundle of the SHA-256 message padder.
interface sha256_msg_padder_if;
  import sha256_pkg::*;

  // Byte handshake: a byte transfers on a rising edge where in_valid and in_ready
  // are both high; the source holds in_byte/in_last/in_valid stable until then.
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_byte;
  logic          in_last;
  logic          core_soc;
  logic [31:0]   core_data;
  logic          core_eoc;
  logic          busy;
  logic          msg_done;
  logic [15:0]   blk_cnt;
  padder_state_t dbg_state;

  modport slave (
    input  in_valid, in_byte, in_last, core_eoc,
    output in_ready, core_soc, core_data, busy, msg_done, blk_cnt, dbg_state
  );

  modport master (
    output in_valid, in_byte, in_last, core_eoc,
    input  in_ready, core_soc, core_data, busy, msg_done, blk_cnt, dbg_state
  );

endinterface

// File: rtl/sha256_blk_buf.sv
// 16x32 block buffer: per-byte write mask, synchronous clear, combinational word read.
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic                               clk,
  input  logic                               i_clr,
  input  logic [SHA_BLK_BYTES-1:0]           i_we,
  input  logic [SHA_BLK_BYTES-1:0][7:0]      i_wbyte,
  input  logic [3:0]                         i_rd_idx,
  output logic [31:0]                        o_rd_word
);

  logic [SHA_BLK_WORDS-1:0][31:0] r_mem;

  // Byte b lives in word b/4; byte 0 of a word is its most significant lane.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_mem <= '0;
    end else begin
      for (int b = 0; b < SHA_BLK_BYTES; b++) begin
        if (i_we[b[5:0]]) begin
          r_mem[b[5:2]][{~b[1:0], 3'b000} +: 8] <= i_wbyte[b[5:0]];
        end
      end
    end
  end

  assign o_rd_word = r_mem[i_rd_idx];

endmodule

// File: rtl/sha256_msg_padder.sv
// Byte-stream to padded 512-bit block feeder for a SHA-256 core (0x80, zero fill, 64-bit length).
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sha256_msg_padder_if.slave   io_pad
);

  padder_state_t     r_state;
  logic [5:0]        r_ptr;
  logic [LEN_W-1:0]  r_len;
  logic [3:0]        r_widx;
  logic              r_final;
  pend_t             r_pend;
  logic              r_core_soc;
  logic [31:0]       r_core_data;
  logic              r_busy;
  logic              r_msg_done;
  logic [15:0]       r_blk_cnt;

  logic                           w_accept;
  logic                           w_eoc_hit;
  logic                           w_build;
  logic                           w_clr;
  logic [SHA_BLK_BYTES-1:0]       w_we;
  logic [SHA_BLK_BYTES-1:0][7:0]  w_wbyte;
  logic [3:0]                     w_rd_idx;
  logic [31:0]                    w_rd_word;
  logic [63:0]                    w_len64;

  assign w_accept  = io_pad.in_valid && (r_state == ST_IDLE || r_state == ST_FILL);
  assign w_eoc_hit = (r_state == ST_WAIT_EOC) && io_pad.core_eoc;
  assign w_build   = w_eoc_hit && !r_final && (r_pend != PEND_NONE);
  assign w_clr     = rst || (w_eoc_hit && !r_final && (r_pend == PEND_NONE));
  assign w_rd_idx  = (r_state == ST_SOC) ? 4'd0 : (r_widx + 4'd1);

  always_comb begin
    w_len64 = '0;
    w_len64[LEN_W-1:0] = r_len;
  end

  // Buffer write source: incoming byte, in-place padding, or a whole generated block.
  always_comb begin
    w_we    = '0;
    w_wbyte = '0;
    if (w_accept) begin
      w_we[r_ptr]    = 1'b1;
      w_wbyte[r_ptr] = io_pad.in_byte;
    end else if (r_state == ST_PAD) begin
      for (int b = 0; b < SHA_BLK_BYTES; b++) begin
        if (r_ptr != 6'd0 && b[5:0] >= r_ptr) begin
          w_we[b[5:0]] = 1'b1;
          if (b[5:0] == r_ptr) begin
            w_wbyte[b[5:0]] = SHA_PAD_BYTE;
          end else if (b >= SHA_LEN_POS && r_ptr < 6'(SHA_LEN_POS)) begin
            w_wbyte[b[5:0]] = len_byte(w_len64, b[2:0]);
          end
        end
      end
    end else if (w_build) begin
      for (int b = 0; b < SHA_BLK_BYTES; b++) begin
        w_we[b[5:0]] = 1'b1;
        if (b >= SHA_LEN_POS) begin
          w_wbyte[b[5:0]] = len_byte(w_len64, b[2:0]);
        end else if (b == 0 && r_pend == PEND_PAD80) begin
          w_wbyte[b[5:0]] = SHA_PAD_BYTE;
        end
      end
    end
  end

  sha256_blk_buf u_buf (
    .clk       (clk),
    .i_clr     (w_clr),
    .i_we      (w_we),
    .i_wbyte   (w_wbyte),
    .i_rd_idx  (w_rd_idx),
    .o_rd_word (w_rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_len       <= '0;
      r_widx      <= '0;
      r_final     <= 1'b0;
      r_pend      <= PEND_NONE;
      r_core_soc  <= 1'b0;
      r_core_data <= '0;
      r_busy      <= 1'b0;
      r_msg_done  <= 1'b0;
      r_blk_cnt   <= '0;
    end else begin
      r_core_soc <= 1'b0;
      r_msg_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FILL: begin
          if (w_accept) begin
            r_ptr  <= r_ptr + 6'd1;
            r_len  <= r_len + LEN_W'(8);
            r_busy <= 1'b1;
            if (io_pad.in_last) begin
              r_state <= ST_PAD;
            end else if (r_ptr == 6'd63) begin
              r_final    <= 1'b0;
              r_pend     <= PEND_NONE;
              r_state    <= ST_SOC;
              r_core_soc <= 1'b1;
              r_blk_cnt  <= r_blk_cnt + 16'd1;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_PAD: begin
          r_state    <= ST_SOC;
          r_core_soc <= 1'b1;
          r_blk_cnt  <= r_blk_cnt + 16'd1;
          // No room for the length trailer means one more, generated, block follows.
          if (r_ptr == 6'd0) begin
            r_final <= 1'b0;
            r_pend  <= PEND_PAD80;
          end else if (r_ptr >= 6'(SHA_LEN_POS)) begin
            r_final <= 1'b0;
            r_pend  <= PEND_ZERO;
          end else begin
            r_final <= 1'b1;
            r_pend  <= PEND_NONE;
          end
        end
        ST_SOC: begin
          r_state     <= ST_SEND;
          r_widx      <= 4'd0;
          r_core_data <= w_rd_word;
        end
        ST_SEND: begin
          if (r_widx == 4'd15) begin
            r_core_data <= '0;
            r_state     <= ST_WAIT_EOC;
          end else begin
            r_core_data <= w_rd_word;
            r_widx      <= r_widx + 4'd1;
          end
        end
        ST_WAIT_EOC: begin
          if (io_pad.core_eoc) begin
            if (r_final) begin
              r_state    <= ST_DONE;
              r_msg_done <= 1'b1;
              r_busy     <= 1'b0;
            end else if (r_pend != PEND_NONE) begin
              r_pend     <= PEND_NONE;
              r_final    <= 1'b1;
              r_state    <= ST_SOC;
              r_core_soc <= 1'b1;
              r_blk_cnt  <= r_blk_cnt + 16'd1;
            end else begin
              r_ptr   <= '0;
              r_state <= ST_FILL;
            end
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_len     <= '0;
          r_blk_cnt <= '0;
          r_ptr     <= '0;
          r_final   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_pad.in_ready  = (r_state == ST_IDLE) || (r_state == ST_FILL);
  assign io_pad.core_soc  = r_core_soc;
  assign io_pad.core_data = r_core_data;
  assign io_pad.busy      = r_busy;
  assign io_pad.msg_done  = r_msg_done;
  assign io_pad.blk_cnt   = r_blk_cnt;
  assign io_pad.dbg_state = r_state;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: padding model, per-cycle output compare, eoc responder, directed messages.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  typedef logic [7:0] byte_q_t [$];

  logic clk;
  logic rst;
  sha256_msg_padder_if pif();

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_pad (pif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int win = 0;
  int soc_seen = 0;
  int eoc_delay = 3;
  bit eoc_noise = 1'b0;
  int eoc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Padded message as a byte list, then cut into big-endian words.
  task automatic model_msg(input byte_q_t msg, output int nblk);
    byte_q_t q;
    logic [63:0] bits;
    q = msg;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) q.push_back(bits[i*8 +: 8]);
    nblk = q.size() / 64;
    for (int i = 0; i < q.size(); i += 4) exp_q.push_back({q[i], q[i+1], q[i+2], q[i+3]});
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        win = 0;
      end else begin
        if (win > 0) begin
          if (exp_q.size() == 0) check("data_unexpected", 64'(exp_q.size()), 64'd1);
          else check("core_data", 64'(pif.core_data), 64'(exp_q.pop_front()));
          check("in_ready_send", 64'(pif.in_ready), 64'd0);
          check("soc_in_window", 64'(pif.core_soc), 64'd0);
          win--;
        end else begin
          check("core_data_idle", 64'(pif.core_data), 64'd0);
          if (pif.core_soc) begin
            check("in_ready_soc", 64'(pif.in_ready), 64'd0);
            check("soc_expected", 64'(exp_q.size() >= 16), 64'd1);
            soc_seen++;
            win = 16;
          end
        end
      end
    end
  end

  // ---------------- core_eoc responder ----------------
  initial begin
    pif.core_eoc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eoc_cnt = 0;
        pif.core_eoc = 1'b0;
      end else begin
        pif.core_eoc = 1'b0;
        if (pif.core_soc) begin
          eoc_cnt = 16 + eoc_delay;
          if (eoc_noise) pif.core_eoc = 1'b1;
        end else if (eoc_cnt > 0) begin
          eoc_cnt--;
          if (eoc_cnt == 0) pif.core_eoc = 1'b1;
          else if (eoc_noise && eoc_cnt > eoc_delay) pif.core_eoc = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_msg(input byte_q_t msg);
    int bud;
    for (int i = 0; i < msg.size(); i++) begin
      pif.in_valid = 1'b1;
      pif.in_byte  = msg[i];
      pif.in_last  = (i == msg.size() - 1);
      bud = 0;
      while (!pif.in_ready && bud < 2000) begin
        @(negedge clk);
        bud++;
      end
      if (bud >= 2000) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
      @(negedge clk);
      if (i == 0) check("busy_after_first", 64'(pif.busy), 64'd1);
    end
    pif.in_valid = 1'b0;
    pif.in_last  = 1'b0;
  endtask

  task automatic wait_soc();
    int bud = 0;
    while (!pif.core_soc && bud < 2000) begin
      @(negedge clk);
      bud++;
    end
    if (bud >= 2000) check("soc_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int nblk);
    int bud = 0;
    while (!pif.msg_done && bud < 3000) begin
      @(negedge clk);
      bud++;
    end
    if (bud >= 3000) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("blk_cnt_done", 64'(pif.blk_cnt), 64'(nblk));
      check("busy_at_done", 64'(pif.busy), 64'd0);
      check("soc_count", 64'(soc_seen), 64'(nblk));
      check("words_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("done_pulse_width", 64'(pif.msg_done), 64'd0);
      check("blk_cnt_cleared", 64'(pif.blk_cnt), 64'd0);
      check("in_ready_idle", 64'(pif.in_ready), 64'd1);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    byte_q_t m;
    int nb;
    rst = 1'b1;
    pif.in_valid = 1'b0;
    pif.in_byte  = 8'h00;
    pif.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(pif.in_ready), 64'd1);
    check("rst_core_soc", 64'(pif.core_soc), 64'd0);
    check("rst_core_data", 64'(pif.core_data), 64'd0);
    check("rst_busy", 64'(pif.busy), 64'd0);
    check("rst_msg_done", 64'(pif.msg_done), 64'd0);
    check("rst_blk_cnt", 64'(pif.blk_cnt), 64'd0);
    check("rst_state", 64'(pif.dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // "abc": single block
    m = '{8'h61, 8'h62, 8'h63};
    eoc_delay = 3; eoc_noise = 1'b0; soc_seen = 0;
    model_msg(m, nb);
    check("model_abc_w0", 64'(exp_q[0]), 64'h61626380);
    check("model_abc_w1", 64'(exp_q[1]), 64'h0);
    check("model_abc_w15", 64'(exp_q[15]), 64'h18);
    send_msg(m);
    wait_done(nb);

    // 55 bytes: last length that fits in one block; eoc on WAIT_EOC entry cycle
    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h61);
    eoc_delay = 1; soc_seen = 0;
    model_msg(m, nb);
    check("model_55_nblk", 64'(nb), 64'd1);
    check("model_55_w13", 64'(exp_q[13]), 64'h61616180);
    check("model_55_w14", 64'(exp_q[14]), 64'h0);
    check("model_55_w15", 64'(exp_q[15]), 64'h1B8);
    send_msg(m);
    wait_done(nb);

    // 56 bytes: 0x80 completes block 1, zero+length block follows; eoc noise while sending
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'(i + 1));
    eoc_delay = 2; eoc_noise = 1'b1; soc_seen = 0;
    model_msg(m, nb);
    check("model_56_nblk", 64'(nb), 64'd2);
    check("model_56_w14", 64'(exp_q[14]), 64'h80000000);
    check("model_56_w15", 64'(exp_q[15]), 64'h0);
    check("model_56_b2w15", 64'(exp_q[31]), 64'h1C0);
    send_msg(m);
    wait_done(nb);
    eoc_noise = 1'b0;

    // 64 bytes: full data block, then 0x80/length block
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'(i * 3));
    eoc_delay = 5; soc_seen = 0;
    model_msg(m, nb);
    check("model_64_b2w0", 64'(exp_q[16]), 64'h80000000);
    check("model_64_b2w15", 64'(exp_q[31]), 64'h200);
    send_msg(m);
    wait_done(nb);

    // 70 bytes with slow core: input held off during the long WAIT_EOC
    m = {};
    for (int i = 0; i < 70; i++) m.push_back(8'(255 - i));
    eoc_delay = 100; soc_seen = 0;
    model_msg(m, nb);
    check("model_70_nblk", 64'(nb), 64'd2);
    fork
      send_msg(m);
      begin
        wait_soc();
        repeat (40) @(negedge clk);
        check("wait_in_ready", 64'(pif.in_ready), 64'd0);
        check("wait_busy", 64'(pif.busy), 64'd1);
        check("wait_state", 64'(pif.dbg_state), 64'(ST_WAIT_EOC));
      end
    join
    wait_done(nb);

    // reset during SEND word 7, then "abc" again
    m = {};
    for (int i = 0; i < 10; i++) m.push_back(8'(i + 8'h30));
    eoc_delay = 3; soc_seen = 0;
    model_msg(m, nb);
    send_msg(m);
    wait_soc();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_core_soc", 64'(pif.core_soc), 64'd0);
    check("midrst_core_data", 64'(pif.core_data), 64'd0);
    check("midrst_busy", 64'(pif.busy), 64'd0);
    check("midrst_in_ready", 64'(pif.in_ready), 64'd1);
    check("midrst_blk_cnt", 64'(pif.blk_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m = '{8'h61, 8'h62, 8'h63};
    soc_seen = 0;
    model_msg(m, nb);
    send_msg(m);
    wait_done(nb);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
